// File: rtl/window_addr_gen_if.sv
// Request/read-address bundle for window_addr_gen; the abort wire exists only when WAG_ABORT_EN is defined.
// The master modport is the requester/memory side and the slave modport is the address generator.
interface window_addr_gen_if #(
    parameter int ADDR_W = 13
);
    logic              start;
    logic              ksize;
    logic [ADDR_W-1:0] img_w;
    logic [ADDR_W-1:0] base_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        row_idx;
    logic [3:0]        col_idx;
    logic              busy;
    logic              done;
`ifdef WAG_ABORT_EN
    logic              abort;
`endif

    modport master (
        output start, ksize, img_w, base_addr, rd_ready,
`ifdef WAG_ABORT_EN
        output abort,
`endif
        input  rd_valid, rd_addr, row_idx, col_idx, busy, done
    );

    modport slave (
        input  start, ksize, img_w, base_addr, rd_ready,
`ifdef WAG_ABORT_EN
        input  abort,
`endif
        output rd_valid, rd_addr, row_idx, col_idx, busy, done
    );
endinterface

// File: rtl/window_addr_gen.sv
// Walks a 3x3/5x5 window row-major and issues one registered read address per accepted cycle.
// First address is valid the cycle after start; rd_ready=0 freezes all outputs. Optional abort: WAG_ABORT_EN.
module window_addr_gen #(
    parameter int ADDR_W = 13
) (
    input logic              CLK,
    input logic              RST,
    window_addr_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state_q, state_d;
    logic              k5_q, k5_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] img_w_q, img_w_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        last_idx;

    always_comb begin
        state_d   = state_q;
        k5_d      = k5_q;
        base_d    = base_q;
        img_w_d   = img_w_q;
        row_off_d = row_off_q;
        addr_d    = addr_q;
        row_d     = row_q;
        col_d     = col_q;
        last_idx  = k5_q ? 4'd4 : 4'd2;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ISSUE;
                    k5_d      = bus.ksize;
                    base_d    = bus.base_addr;
                    img_w_d   = bus.img_w;
                    row_off_d = '0;
                    addr_d    = bus.base_addr;
                    row_d     = 4'd0;
                    col_d     = 4'd0;
                end
            end
            ISSUE: begin
`ifdef WAG_ABORT_EN
                if (bus.abort) begin
                    state_d   = IDLE;
                    row_off_d = '0;
                    addr_d    = '0;
                    row_d     = 4'd0;
                    col_d     = 4'd0;
                end else
`endif
                if (bus.rd_ready) begin
                    if (col_q != last_idx) begin
                        col_d  = col_q + 4'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end else if (row_q != last_idx) begin
                        // Next row starts from the accumulated pitch, never from a multiply.
                        col_d     = 4'd0;
                        row_d     = row_q + 4'd1;
                        row_off_d = row_off_q + img_w_q;
                        addr_d    = base_q + row_off_q + img_w_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            k5_q      <= 1'b0;
            base_q    <= '0;
            img_w_q   <= '0;
            row_off_q <= '0;
            addr_q    <= '0;
            row_q     <= 4'd0;
            col_q     <= 4'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k5_q      <= k5_d;
            base_q    <= base_d;
            img_w_q   <= img_w_d;
            row_off_q <= row_off_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rd_valid = valid_q;
    assign bus.rd_addr  = addr_q;
    assign bus.row_idx  = row_q;
    assign bus.col_idx  = col_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen: 3x3/5x5 streams, backpressure, wrap, start-while-busy, reset, abort.
module tb_window_addr_gen;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    window_addr_gen_if #(.ADDR_W(13)) bus ();

    window_addr_gen #(.ADDR_W(13)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [12:0] exp3  [9] = '{13'd100, 13'd101, 13'd102, 13'd128, 13'd129, 13'd130, 13'd156, 13'd157, 13'd158};
    logic [12:0] expw  [9] = '{13'd8190, 13'd8191, 13'd0, 13'd8191, 13'd0, 13'd1, 13'd0, 13'd1, 13'd2};
    logic [12:0] expb  [9] = '{13'd40, 13'd41, 13'd42, 13'd60, 13'd61, 13'd62, 13'd80, 13'd81, 13'd82};

    // Pulses start for one edge, then scrambles the latched inputs to prove they are ignored.
    task automatic start_win(input logic [12:0] b, input logic [12:0] w, input logic k);
        @(negedge CLK);
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.img_w     = w;
        bus.ksize     = k;
        @(negedge CLK);
        bus.start     = 1'b0;
        bus.base_addr = 13'h1555;
        bus.img_w     = 13'd3;
        bus.ksize     = ~k;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.rd_addr !== 13'd0 || bus.row_idx !== 4'd0 || bus.col_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_values got v=%b b=%b d=%b a=%0d r=%0d c=%0d exp all zero",
                     bus.rd_valid, bus.busy, bus.done, bus.rd_addr, bus.row_idx, bus.col_idx);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got v=%b b=%b exp 0 0", bus.rd_valid, bus.busy);
        end
    endtask

    task automatic test_3x3;
        bus.rd_ready = 1'b1;
        start_win(13'd100, 13'd28, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_addr !== exp3[i] ||
                bus.row_idx !== 4'(i / 3) || bus.col_idx !== 4'(i % 3)) begin
                errors++;
                $display("FAIL 3x3_addr i=%0d got v=%b a=%0d r=%0d c=%0d exp v=1 a=%0d r=%0d c=%0d",
                         i, bus.rd_valid, bus.rd_addr, bus.row_idx, bus.col_idx, exp3[i], i / 3, i % 3);
            end
            @(negedge CLK);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL 3x3_done got d=%b v=%b b=%b exp 1 0 1", bus.done, bus.rd_valid, bus.busy);
        end
        @(negedge CLK);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL 3x3_idle got d=%b b=%b exp 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_5x5_backpressure;
        int idx;
        int cyc;
        logic [12:0] ea;
        bus.rd_ready = 1'b1;
        start_win(13'd0, 13'd10, 1'b1);
        idx = 0;
        cyc = 0;
        while (idx < 25 && cyc < 100) begin
            ea = 13'((idx / 5) * 10 + (idx % 5));
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_addr !== ea ||
                bus.row_idx !== 4'(idx / 5) || bus.col_idx !== 4'(idx % 5)) begin
                errors++;
                $display("FAIL 5x5_addr idx=%0d cyc=%0d got v=%b a=%0d r=%0d c=%0d exp v=1 a=%0d r=%0d c=%0d",
                         idx, cyc, bus.rd_valid, bus.rd_addr, bus.row_idx, bus.col_idx, ea, idx / 5, idx % 5);
            end
            if (bus.rd_ready) idx++;
            @(negedge CLK);
            bus.rd_ready = ~bus.rd_ready;
            cyc++;
        end
        checks++;
        if (idx != 25) begin
            errors++;
            $display("FAIL 5x5_timeout got accepted=%0d exp 25", idx);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL 5x5_done got d=%b v=%b exp 1 0", bus.done, bus.rd_valid);
        end
        bus.rd_ready = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_wrap;
        bus.rd_ready = 1'b1;
        start_win(13'd8190, 13'd1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_addr !== expw[i]) begin
                errors++;
                $display("FAIL wrap_addr i=%0d got v=%b a=%0d exp v=1 a=%0d", i, bus.rd_valid, bus.rd_addr, expw[i]);
            end
            @(negedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic test_start_while_busy;
        logic [12:0] ea;
        bus.rd_ready = 1'b1;
        start_win(13'd40, 13'd20, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_addr !== expb[i]) begin
                errors++;
                $display("FAIL busy_addr i=%0d got v=%b a=%0d exp v=1 a=%0d", i, bus.rd_valid, bus.rd_addr, expb[i]);
            end
            bus.start     = (i == 4);
            bus.base_addr = 13'd500;
            bus.img_w     = 13'd7;
            bus.ksize     = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL busy_done got d=%b exp 1", bus.done);
        end
        bus.start = 1'b1;
        bus.ksize = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done got b=%b v=%b exp 0 0", bus.busy, bus.rd_valid);
        end
        @(negedge CLK);
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ea = 13'(500 + (i / 3) * 7 + (i % 3));
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_addr !== ea) begin
                errors++;
                $display("FAIL restart_addr i=%0d got v=%b a=%0d exp v=1 a=%0d", i, bus.rd_valid, bus.rd_addr, ea);
            end
            @(negedge CLK);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got d=%b exp 1", bus.done);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        int done_seen;
        bus.rd_ready = 1'b1;
        start_win(13'd200, 13'd30, 1'b1);
        repeat (4) @(negedge CLK);
        checks++;
        if (bus.rd_addr !== 13'd204 || bus.col_idx !== 4'd4) begin
            errors++;
            $display("FAIL pre_reset_addr got a=%0d c=%0d exp a=204 c=4", bus.rd_addr, bus.col_idx);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.rd_addr !== 13'd0 || bus.row_idx !== 4'd0 || bus.col_idx !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b b=%b d=%b a=%0d r=%0d c=%0d exp all zero",
                     bus.rd_valid, bus.busy, bus.done, bus.rd_addr, bus.row_idx, bus.col_idx);
        end
        @(negedge CLK);
        RST = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_no_done got active_cycles=%0d exp 0", done_seen);
        end
        start_win(13'd300, 13'd5, 1'b0);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 13'd300 || bus.row_idx !== 4'd0 || bus.col_idx !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_start got v=%b a=%0d r=%0d c=%0d exp 1 300 0 0",
                     bus.rd_valid, bus.rd_addr, bus.row_idx, bus.col_idx);
        end
        repeat (12) @(negedge CLK);
    endtask

`ifdef WAG_ABORT_EN
    task automatic test_abort;
        int done_seen;
        int waited;
        bus.rd_ready = 1'b1;
        start_win(13'd20, 13'd10, 1'b0);
        repeat (5) @(negedge CLK);
        checks++;
        if (bus.rd_addr !== 13'd32 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_6th_addr got v=%b a=%0d exp 1 32", bus.rd_valid, bus.rd_addr);
        end
        bus.abort = 1'b1;
        @(negedge CLK);
        bus.abort = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got v=%b b=%b d=%b exp 0 0 0", bus.rd_valid, bus.busy, bus.done);
        end
        done_seen = 0;
        repeat (5) begin
            @(negedge CLK);
            if (bus.done !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done got pulses=%0d exp 0", done_seen);
        end
        start_win(13'd60, 13'd10, 1'b0);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 13'd60 || bus.row_idx !== 4'd0 || bus.col_idx !== 4'd0) begin
            errors++;
            $display("FAIL abort_restart got v=%b a=%0d r=%0d c=%0d exp 1 60 0 0",
                     bus.rd_valid, bus.rd_addr, bus.row_idx, bus.col_idx);
        end
        waited = 0;
        while (bus.done !== 1'b1 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        checks++;
        if (waited != 9) begin
            errors++;
            $display("FAIL abort_restart_done got cycles=%0d exp 9", waited);
        end
        @(negedge CLK);
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        RST           = 1'b0;
        bus.start     = 1'b0;
        bus.ksize     = 1'b0;
        bus.img_w     = '0;
        bus.base_addr = '0;
        bus.rd_ready  = 1'b0;
`ifdef WAG_ABORT_EN
        bus.abort     = 1'b0;
`endif
        #1 RST = 1'b1;
        test_reset();
        test_3x3();
        test_5x5_backpressure();
        test_wrap();
        test_start_while_busy();
        test_reset_mid();
`ifdef WAG_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
